// File: rtl/load_store_unit_if.sv
// Request and memory-port bundle for the load/store unit.
// Handshake: the master raises req_valid with its fields and holds them
// until it observes req_ready=1 at a rising edge; that edge accepts the
// request. The slave ignores req_valid while busy and signals completion
// with a single-cycle done pulse (err is meaningful only with done).
// The master side is the pipeline plus the data memory, so it also
// supplies mem_rdata, which is combinational from mem_addr.
interface load_store_unit_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              err;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rdata, done, err,
        input  mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rdata, done, err,
        output mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline load/store into single-beat memory
// accesses, splitting misaligned requests and extending load data.
module load_store_unit #(
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.slave    bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        n_q;
    logic [1:0]        b_q;
    logic [31:0]       w0_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    // Beat count for a request; 0 marks an illegal funct3.
    function automatic logic [2:0] beat_count(input logic we, input logic [2:0] f3,
                                              input logic [1:0] o);
        logic [2:0] n;
        n = 3'd0;
        if (we) begin
            case (f3)
                3'd0:    n = 3'd1;
                3'd1:    n = o[0] ? 3'd2 : 3'd1;
                3'd2:    n = (o != 2'd0) ? 3'd4 : 3'd1;
                default: n = 3'd0;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: n = 3'd1;
                3'd1, 3'd5: n = (o == 2'd3) ? 3'd2 : 3'd1;
                3'd2:       n = (o != 2'd0) ? 3'd2 : 3'd1;
                default:    n = 3'd0;
            endcase
        end
        return n;
    endfunction

    logic [2:0]  acc_n;
    logic        last_beat;
    logic [63:0] pair;
    logic [63:0] shifted;
    logic [31:0] load_val;

    assign acc_n     = beat_count(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign last_beat = ({1'b0, b_q} == (n_q - 3'd1));

    // Load result from the word pair; the final beat's word comes straight
    // from mem_rdata so the result can be registered on entry to DONE.
    always_comb begin
        pair     = (n_q == 3'd2) ? {bus.mem_rdata, w0_q} : {32'd0, bus.mem_rdata};
        shifted  = pair >> {addr_q[1:0], 3'b000};
        load_val = shifted[31:0];
        case (f3_q[1:0])
            2'd0:    load_val = {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted[31:0];
        endcase
    end

    // Control FSM: accept, step beats, pulse done; holds request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            n_q     <= 3'd0;
            b_q     <= 2'd0;
            w0_q    <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        n_q     <= acc_n;
                        b_q     <= 2'd0;
                        err_q   <= (acc_n == 3'd0);
                        state   <= (acc_n == 3'd0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (!we_q && b_q == 2'd0) begin
                        w0_q <= bus.mem_rdata;
                    end
                    if (last_beat) begin
                        state <= DONE;
                        if (!we_q) begin
                            rdata_q <= load_val;
                        end
                    end else begin
                        b_q <= b_q + 2'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.done      = (state == DONE);
    assign bus.err       = (state == DONE) && err_q;
    assign bus.rdata     = rdata_q;
    assign dbg_state     = state;

    // Memory port decode: active only in BUSY, one access per beat.
    always_comb begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_funct3 = 3'd0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = 32'd0;
        if (state == BUSY) begin
            if (!we_q) begin
                bus.mem_read   = 1'b1;
                bus.mem_funct3 = 3'd2;
                bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'({b_q, 2'b00});
            end else if (n_q == 3'd1) begin
                bus.mem_write  = 1'b1;
                bus.mem_funct3 = f3_q;
                bus.mem_addr   = addr_q;
                bus.mem_wdata  = wdata_q;
            end else begin
                bus.mem_write  = 1'b1;
                bus.mem_funct3 = 3'd0;
                bus.mem_addr   = addr_q + ADDR_W'(b_q);
                bus.mem_wdata  = {24'd0, wdata_q[{b_q, 3'b000} +: 8]};
            end
        end
    end
endmodule
